// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: canonical NOP, fetch fault codes and fetch FSM states.
package riscv_pkg;

    localparam logic [31:0] NOP            = 32'h0000_0013;

    localparam logic [1:0]  FAULT_OK       = 2'b00;
    localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
    localparam logic [1:0]  FAULT_RANGE    = 2'b10;

    typedef enum logic {
        CLEAR,
        RUN
    } fetch_state_e;

endpackage

// File: rtl/imem_fetch_if.sv
// Fetch request/response handshake between the PC stage (master) and instruction memory (slave).
interface imem_fetch_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_instr;
    logic [1:0]        resp_fault;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_instr, resp_fault
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_instr, resp_fault
    );
endinterface

// File: rtl/imem_ram.sv
// Simple dual-port word array: one write port, one registered read port (read-before-write).
module imem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // rdata only moves when re is set, so it doubles as the held response word.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata      <= mem[raddr];
    end
endmodule

// File: rtl/imem_fetch.sv
// Instruction memory with a write-only load port and a 1-cycle valid/ready fetch port.
module imem_fetch
    import riscv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_err,
    output logic              busy,
    imem_fetch_if.slave       fetch
);
    localparam int                IDX_W = $clog2(DEPTH);
    localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP);

    fetch_state_e      state, state_nx;
    logic [IDX_W-1:0]  clr_cnt, clr_cnt_nx;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              load_bad;
    logic              req_misalign, req_range, accept;
    logic [1:0]        req_fault;
    logic              resp_ok;

    assign load_bad     = (|load_addr[1:0]) || (|load_addr[ADDR_W-1:IDX_W+2]);
    assign req_misalign = |fetch.req_addr[1:0];
    assign req_range    = |fetch.req_addr[ADDR_W-1:IDX_W+2];
    assign req_fault    = req_misalign ? FAULT_MISALIGN :
                          req_range    ? FAULT_RANGE    : FAULT_OK;

    assign busy            = (state == CLEAR);
    assign fetch.req_ready = (state == RUN) && (!fetch.resp_valid || fetch.resp_ready);
    assign accept          = fetch.req_valid && fetch.req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
        end
    end

    // The clear sweep owns the write port; loads only reach it in RUN.
    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        ram_we     = 1'b0;
        ram_waddr  = load_addr[IDX_W+1:2];
        ram_wdata  = load_data;
        case (state)
            CLEAR: begin
                ram_we     = 1'b1;
                ram_waddr  = clr_cnt;
                ram_wdata  = NOP_W;
                clr_cnt_nx = clr_cnt + 1'b1;
                if (clr_cnt == IDX_W'(DEPTH - 1)) state_nx = RUN;
            end
            RUN: begin
                ram_we = load_en && !load_bad;
            end
        endcase
    end

    imem_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .re   (accept),
        .raddr(fetch.req_addr[IDX_W+1:2]),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch.resp_valid <= 1'b0;
            fetch.resp_fault <= FAULT_OK;
            resp_ok          <= 1'b0;
        end else if (accept) begin
            fetch.resp_valid <= 1'b1;
            fetch.resp_fault <= req_fault;
            resp_ok          <= (req_fault == FAULT_OK);
        end else if (fetch.resp_ready) begin
            fetch.resp_valid <= 1'b0;
        end
    end

    // Faulted or reset responses substitute NOP for the (unreset) RAM read register.
    assign fetch.resp_instr = resp_ok ? ram_rdata : NOP_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) load_err <= 1'b0;
        else        load_err <= (state == RUN) && load_en && load_bad;
    end
endmodule

// File: tb/tb_imem_fetch.sv
// Scoreboard bench for imem_fetch: directed plan plus random traffic against a word-array model.
module tb_imem_fetch;
    import riscv_pkg::*;

    localparam int DEPTH = 64;

    typedef struct packed {
        logic [31:0] instr;
        logic [1:0]  fault;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        load_err;
    logic        busy;

    imem_fetch_if #(.DATA_W(32), .ADDR_W(32)) fif ();

    imem_fetch #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .load_err (load_err),
        .busy     (busy),
        .fetch    (fif)
    );

    always #5 clk = ~clk;

    resp_t       exp_q[$];
    logic [31:0] mm [DEPTH];
    bit          m_holding;
    bit          m_err;
    int unsigned vectors;
    int unsigned miscompares;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic resp_t model_fetch(input logic [31:0] a);
        resp_t r;
        r.instr = NOP;
        r.fault = FAULT_OK;
        if (a % 4 != 0)             r.fault = FAULT_MISALIGN;
        else if (a / 4 >= DEPTH)    r.fault = FAULT_RANGE;
        else                        r.instr = mm[a / 4];
        return r;
    endfunction

    function automatic bit load_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= DEPTH);
    endfunction

    // Monitor: just before each rising edge, compare the presented response with the queue head.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && fif.resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 32'(fif.resp_valid), 32'd0);
                end else begin
                    chk("resp_instr", fif.resp_instr, exp_q[0].instr);
                    chk("resp_fault", 32'(fif.resp_fault), 32'(exp_q[0].fault));
                    if (fif.resp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cycle(input logic v, input logic [31:0] a, input logic rr,
                         input logic le, input logic [31:0] la, input logic [31:0] ld);
        bit exp_ready;
        @(negedge clk);
        fif.req_valid  = v;
        fif.req_addr   = a;
        fif.resp_ready = rr;
        load_en        = le;
        load_addr      = la;
        load_data      = ld;
        #1;
        exp_ready = !m_holding || rr;
        chk("resp_valid", 32'(fif.resp_valid), 32'(m_holding));
        chk("req_ready", 32'(fif.req_ready), 32'(exp_ready));
        chk("busy_run", 32'(busy), 32'd0);
        chk("load_err", 32'(load_err), 32'(m_err));
        if (v && exp_ready) exp_q.push_back(model_fetch(a));
        if (v && exp_ready) m_holding = 1'b1;
        else if (rr)        m_holding = 1'b0;
        m_err = le && load_bad(la);
        if (le && !load_bad(la)) mm[la / 4] = ld;
    endtask

    task automatic reset_and_clear();
        int n;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_resp_valid", 32'(fif.resp_valid), 32'd0);
        chk("rst_resp_instr", fif.resp_instr, NOP);
        chk("rst_resp_fault", 32'(fif.resp_fault), 32'd0);
        chk("rst_req_ready", 32'(fif.req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_load_err", 32'(load_err), 32'd0);
        exp_q.delete();
        m_holding = 1'b0;
        m_err     = 1'b0;
        for (int i = 0; i < DEPTH; i++) mm[i] = NOP;
        repeat (2) @(negedge clk);
        // Hold a fetch and a stray load to word 0 through the whole clear sweep.
        fif.req_valid  = 1'b1;
        fif.req_addr   = '0;
        fif.resp_ready = 1'b1;
        load_en        = 1'b1;
        load_addr      = '0;
        load_data      = 32'hBAD0_BAD0;
        rst_n          = 1'b1;
        #1;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            chk("clear_req_ready", 32'(fif.req_ready), 32'd0);
            chk("clear_load_err", 32'(load_err), 32'd0);
            n++;
            @(negedge clk);
            #1;
        end
        chk("clear_cycles", 32'(n), 32'd64);
        load_en = 1'b0;
        exp_q.push_back(model_fetch(32'h0));
        m_holding = 1'b1;
    endtask

    initial begin
        logic [31:0] a, la;
        fif.req_valid  = 1'b0;
        fif.req_addr   = '0;
        fif.resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset_and_clear();

        cycle(1'b0, 32'h0,   1'b1, 1'b1, 32'h10, 32'h0020_8193);
        cycle(1'b1, 32'h10,  1'b1, 1'b0, 32'h0,  32'h0);
        cycle(1'b1, 32'h12,  1'b1, 1'b0, 32'h0,  32'h0);
        cycle(1'b1, 32'h100, 1'b1, 1'b0, 32'h0,  32'h0);
        cycle(1'b1, 32'h102, 1'b1, 1'b0, 32'h0,  32'h0);
        cycle(1'b0, 32'h0,   1'b1, 1'b1, 32'h101, 32'hFFFF_FFFF);
        cycle(1'b1, 32'h0,   1'b1, 1'b0, 32'h0,  32'h0);
        cycle(1'b1, 32'h10,  1'b1, 1'b0, 32'h0,  32'h0);

        cycle(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        repeat (3) cycle(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 32'h0);
        cycle(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);

        cycle(1'b1, 32'h20, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
        cycle(1'b1, 32'h20, 1'b1, 1'b0, 32'h0,  32'h0);

        repeat (400) begin
            a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH + 7) * 4);
            if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
            la = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH + 3) * 4);
            if ($urandom_range(0, 5) == 0) la = la | 32'($urandom_range(1, 3));
            cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, la, $urandom);
        end

        cycle(1'b1, 32'h10, 1'b1, 1'b1, 32'h10, 32'h1234_5678);
        cycle(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0);
        reset_and_clear();
        cycle(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 32'h0);
        cycle(1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 32'h0);
        cycle(1'b1, 32'hFC, 1'b1, 1'b0, 32'h0, 32'h0);

        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule

// File: doc/imem_fetch.md
# imem_fetch

Parametrised instruction memory with a fetch handshake, replacing the fixed 64-word combinational instruction store. It holds program words in an internal dual-port array. A write-only load port fills the array, and a valid/ready fetch port returns one instruction per accepted address with one cycle of latency and full throughput under backpressure. After reset it clears every word to NOP before accepting fetches. It sits between the PC/fetch stage and the decode stage of the RISC-V core.

## Interface
- DATA_W, 32, instruction word width in bits
- ADDR_W, 32, byte-address width
- DEPTH, 64, number of words; a power of two, ≥ 2; IDX_W = clog2(DEPTH)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- load_en  input  1  write one program word this cycle
- load_addr  input  ADDR_W  byte address of the word to load
- load_data  input  DATA_W  word to load
- load_err  output  1  one-cycle pulse: the last load was dropped (misaligned or out of range)
- busy  output  1  high while the array is being cleared
- req_valid  input  1  fetch request valid
- req_ready  output  1  fetch request can be accepted
- req_addr  input  ADDR_W  fetch byte address
- resp_valid  output  1  response valid
- resp_ready  input  1  consumer accepts the response
- resp_instr  output  DATA_W  fetched instruction
- resp_fault  output  2  00 ok, 01 misaligned, 10 out of range

## Operation
- FSM has two states, CLEAR and RUN.
- Reset (asynchronous, may occur mid-operation):
  - state = CLEAR, clear counter = 0, busy = 1.
  - resp_valid = 0, resp_instr = NOP (32'h00000013), resp_fault = 00, req_ready = 0, load_err = 0.
  - Any in-flight response is discarded.
- CLEAR:
  - Writes NOP to word[counter] each cycle and increments the counter.
  - After word DEPTH-1 is written, moves to RUN on the next edge. Total time is DEPTH cycles.
  - load_en is ignored and load_err is not raised.
- RUN:
  - busy = 0.
  - req_ready = !resp_valid || resp_ready.
  - A request is accepted when req_valid && req_ready.
- Fault classification, evaluated at acceptance:
  - req_addr[1:0] != 0 gives 01. Misaligned takes priority over out of range.
  - Otherwise req_addr >> 2 ≥ DEPTH gives 10.
  - Otherwise 00, and resp_instr = word[req_addr[IDX_W+1:2]].
  - A faulted response carries resp_instr = NOP.
- Output register:
  - Loaded on acceptance.
  - Held stable, with resp_valid high, until resp_valid && resp_ready.
  - Handshake on both sides in the same cycle: the old response retires and the new one loads, so there is no bubble.
- Load port, RUN only:
  - A valid load writes word[load_addr[IDX_W+1:2]].
  - A misaligned or out-of-range load is dropped and load_err pulses on the next cycle.
  - Loads are never backpressured.
- Load and fetch to the same word in the same cycle: the fetch returns the old contents (read-before-write). The new word is visible to fetches accepted from the next cycle on.

## Timing
- Fetch latency is 1 cycle: accepted at edge N, resp_valid is high after edge N.
- Throughput is 1 fetch/cycle while resp_ready = 1.
- req_ready is combinational from resp_valid, resp_ready and state. There is no combinational path from req_valid to req_ready.
- resp_* are registered outputs only.
- load_err is registered, 1 cycle after the offending load.
- First fetch is accepted no earlier than DEPTH cycles after rst_n deasserts.

## Structure
- Shared package riscv_pkg holds:
  - the NOP constant (32'h00000013);
  - the fault-code localparams FAULT_OK, FAULT_MISALIGN, FAULT_RANGE.
- Sub-module imem_ram: simple dual-port array, one write port and one synchronous registered read port with read-before-write, parametrised by DATA_W and DEPTH.
- FSM, clear counter, address checks and output handshake register live in imem_fetch.

## Test plan
- Reset, then hold req_valid = 1 → busy = 1 and req_ready = 0 for exactly 64 cycles; the first response is 32'h00000013 with fault 00.
- Load 32'h00208193 at 0x10, then fetch 0x10 → resp_instr = 32'h00208193, fault 00, one cycle after acceptance.
- Fetch 0x12, 0x100 and 0x102 → faults 01, 10 and 01, each with resp_instr = NOP. Load to 0x101 → load_err pulses, memory unchanged.
- Back-to-back fetches 0x0, 0x4, 0x8 with resp_ready held low for 3 cycles after the first → 0x0 response held stable, req_ready = 0, no request lost; the remaining responses arrive on consecutive cycles after release.
- Same-cycle load 32'hDEADBEEF and fetch at 0x20 (old value 32'h00000013) → response 32'h00000013; the next fetch of 0x20 returns 32'hDEADBEEF.
- Assert rst_n = 0 while resp_valid = 1 and resp_ready = 0 → resp_valid drops immediately, and the block re-enters CLEAR with all words NOP.
